// File: rtl/text_screen_ctrl_if.sv
// Character-writer port of the text screen controller: a valid/ready character
// stream, a clear-screen request, and the busy/cursor status sent back.
interface text_screen_ctrl_if;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_ready;
    logic       clr_req;
    logic       busy;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    modport master (
        output wr_valid, wr_char, clr_req,
        input  wr_ready, busy, cursor_x, cursor_y
    );

    modport slave (
        input  wr_valid, wr_char, clr_req,
        output wr_ready, busy, cursor_x, cursor_y
    );
endinterface

// File: rtl/text_screen_ctrl.sv
// VGA text-mode screen controller: tile RAM, writer FSM with cursor/clear, and a
// 3-clk tile -> font ROM -> pixel pipeline. Optional blinking cursor: CURSOR_BLINK_EN.
module text_screen_ctrl #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [2:0] FG_RGB       = 3'b010,
    parameter logic [2:0] BG_RGB       = 3'b000,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    text_screen_ctrl_if.slave  wr_bus,
    output logic [10:0]        rom_addr,
    input  logic [7:0]         font_word,
    output logic [2:0]         rgb_text
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] COLS_W   = 8'(COLS);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;

    if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 32 || BLINK_FRAMES < 1) begin : g_param_check
        $error("text_screen_ctrl: COLS, ROWS or BLINK_FRAMES out of range");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t     state;
    logic [6:0] clr_col;
    logic [4:0] clr_row;
    logic [6:0] cur_x;
    logic [4:0] cur_y;

    logic       accept;
    logic       is_print;
    logic [4:0] next_row;

    assign wr_bus.wr_ready = (state == ST_IDLE) && !wr_bus.clr_req;
    assign wr_bus.busy     = (state == ST_CLEAR);
    assign wr_bus.cursor_x = cur_x;
    assign wr_bus.cursor_y = cur_y;

    assign accept   = wr_bus.wr_ready && wr_bus.wr_valid;
    assign is_print = (wr_bus.wr_char >= CH_SPACE) && (wr_bus.wr_char <= CH_TILDE);
    assign next_row = (cur_y == LAST_ROW) ? 5'd0 : cur_y + 5'd1;

    // Tile RAM write port, shared between the clear sweep and the character writer.
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [6:0]  ram_wdata;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
        ram_we    = 1'b0;
        ram_waddr = {clr_row, clr_col};
        ram_wdata = CH_SPACE;
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (accept) begin
            if (is_print) begin
                ram_we    = 1'b1;
                ram_waddr = {cur_y, cur_x};
                ram_wdata = wr_bus.wr_char;
            end else if (wr_bus.wr_char == CH_BS && cur_x != 7'd0) begin
                ram_we    = 1'b1;
                ram_waddr = {cur_y, cur_x - 7'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever assigned with <=, so every register sees pre-edge values.
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_col <= 7'd0;
            clr_row <= 5'd0;
            cur_x   <= 7'd0;
            cur_y   <= 5'd0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_col == LAST_COL) begin
                        clr_col <= 7'd0;
                        if (clr_row == LAST_ROW) begin
                            clr_row <= 5'd0;
                            state   <= ST_IDLE;
                        end else begin
                            clr_row <= clr_row + 5'd1;
                        end
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (wr_bus.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_col <= 7'd0;
                        clr_row <= 5'd0;
                        cur_x   <= 7'd0;
                        cur_y   <= 5'd0;
                    end else if (wr_bus.wr_valid) begin
                        if (is_print) begin
                            if (cur_x == LAST_COL) begin
                                cur_x <= 7'd0;
                                cur_y <= next_row;
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
                        end else begin
                            // Control codes other than BS/LF/CR are consumed without effect.
                            case (wr_bus.wr_char)
                                CH_CR: cur_x <= 7'd0;
                                CH_LF: begin
                                    cur_x <= 7'd0;
                                    cur_y <= next_row;
                                end
                                CH_BS: if (cur_x != 7'd0) cur_x <= cur_x - 7'd1;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    logic [6:0] tile_ram [0:4095];

    // NOTE: the tile RAM has no reset; its contents come from the clear sweep that follows reset.
    always_ff @(posedge clk) begin
        if (ram_we) tile_ram[ram_waddr] <= ram_wdata;
    end

    logic [11:0] rd_addr;
    logic        in_range;
    logic [6:0]  tile_data;
    logic [3:0]  glyph_row_d1;
    logic [2:0]  bit_d1, bit_d2;
    logic        vis_d1, vis_d2;
    logic [2:0]  bit_sel;
    logic        glyph_on;
    logic        pix_on;

    assign rd_addr  = {pixel_y[8:4], pixel_x[9:3]};
    assign in_range = !pixel_y[9] && ({1'b0, pixel_x[9:3]} < COLS_W) && ({1'b0, pixel_y[8:4]} < ROWS_W);
    assign rom_addr = {tile_data, glyph_row_d1};
    // Bit 7 of a font word is the leftmost pixel of the glyph row.
    assign bit_sel  = ~bit_d2;
    assign glyph_on = font_word[bit_sel];

`ifdef CURSOR_BLINK_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_on;
    logic               cur_hit_d1, cur_hit_d2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt  <= '0;
            blink_on   <= 1'b0;
            cur_hit_d1 <= 1'b0;
            cur_hit_d2 <= 1'b0;
        end else begin
            if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
                if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            cur_hit_d1 <= blink_on && (state == ST_IDLE) && !pixel_y[9]
                          && (pixel_x[9:3] == cur_x) && (pixel_y[8:4] == cur_y);
            cur_hit_d2 <= cur_hit_d1;
        end
    end

    assign pix_on = glyph_on ^ cur_hit_d2;
`else
    assign pix_on = glyph_on;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tile_data    <= 7'd0;
            glyph_row_d1 <= 4'd0;
            bit_d1       <= 3'd0;
            bit_d2       <= 3'd0;
            vis_d1       <= 1'b0;
            vis_d2       <= 1'b0;
            rgb_text     <= BG_RGB;
        end else begin
            tile_data    <= tile_ram[rd_addr];
            glyph_row_d1 <= pixel_y[3:0];
            bit_d1       <= pixel_x[2:0];
            bit_d2       <= bit_d1;
            vis_d1       <= video_on && in_range;
            vis_d2       <= vis_d1;
            rgb_text     <= (vis_d2 && pix_on) ? FG_RGB : BG_RGB;
        end
    end
endmodule

// File: tb/tb_text_screen_ctrl.sv
// Directed bench for text_screen_ctrl: clear timing, cursor/char vectors,
// tile contents observed through rom_addr, and pixel pipeline latency.
module tb_text_screen_ctrl;
    localparam logic [2:0] FG = 3'b010;
    localparam logic [2:0] BG = 3'b000;
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [10:0] rom_addr;
    logic [7:0]  font_word;
    logic [2:0]  rgb_text;

    text_screen_ctrl_if wr_bus();

    text_screen_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .wr_bus    (wr_bus),
        .rom_addr  (rom_addr),
        .font_word (font_word),
        .rgb_text  (rgb_text)
    );

    always #5 clk = ~clk;

    // Font ROM stand-in: one glyph row of 'A' is 8'h10, everything else is solid.
    function automatic logic [7:0] font_fn(input logic [10:0] a);
        return (a == 11'h415) ? 8'h10 : 8'hFF;
    endfunction

    always @(posedge clk) font_word <= font_fn(rom_addr);

    typedef struct {
        logic [6:0] ch;
        int         reps;
        logic [6:0] exp_x;
        logic [4:0] exp_y;
    } char_vec_t;

    typedef struct {
        logic [6:0] col;
        logic [4:0] row;
        logic [6:0] exp;
    } cell_vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic put_char(input logic [6:0] ch);
        int guard = 0;
        while (wr_bus.wr_ready !== 1'b1 && guard < LIMIT) begin
            cycle();
            guard++;
        end
        if (guard >= LIMIT) check("put_char wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_char  = ch;
        cycle();
        wr_bus.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (wr_bus.busy === 1'b1 && n < LIMIT) begin
            cycle();
            n++;
        end
    endtask

    task automatic read_cell(input logic [6:0] col, input logic [4:0] row, output logic [6:0] v);
        pixel_x = {col, 3'b000};
        pixel_y = {1'b0, row, 4'b0000};
        cycle();
        v = rom_addr[10:4];
    endtask

    // Present one pixel for one clock, then return rgb_text three edges later.
    task automatic probe_pixel(input logic [9:0] x, input logic [9:0] y, input logic vid,
                               output logic [2:0] rgb);
        pixel_x  = x;
        pixel_y  = y;
        video_on = vid;
        cycle();
        video_on = 1'b0;
        cycle();
        cycle();
        rgb = rgb_text;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        char_vec_t  cvec [14];
        cell_vec_t  tvec [10];
        int         n;
        logic [6:0] v;
        logic [2:0] rgb;

        // Cursor starts at (1,0) when this table is applied.
        cvec[0]  = '{7'h42, 79,  7'd0, 5'd1};
        cvec[1]  = '{7'h0A, 1,   7'd0, 5'd2};
        cvec[2]  = '{7'h61, 5,   7'd5, 5'd2};
        cvec[3]  = '{7'h08, 1,   7'd4, 5'd2};
        cvec[4]  = '{7'h0D, 1,   7'd0, 5'd2};
        cvec[5]  = '{7'h08, 1,   7'd0, 5'd2};
        cvec[6]  = '{7'h01, 1,   7'd0, 5'd2};
        cvec[7]  = '{7'h7F, 1,   7'd0, 5'd2};
        cvec[8]  = '{7'h7E, 1,   7'd1, 5'd2};
        cvec[9]  = '{7'h0A, 27,  7'd0, 5'd29};
        cvec[10] = '{7'h0A, 1,   7'd0, 5'd0};
        cvec[11] = '{7'h0A, 29,  7'd0, 5'd29};
        cvec[12] = '{7'h5A, 79,  7'd79, 5'd29};
        cvec[13] = '{7'h42, 1,   7'd0, 5'd0};

        tvec[0] = '{7'd0,  5'd0,  7'h41};
        tvec[1] = '{7'd1,  5'd0,  7'h42};
        tvec[2] = '{7'd79, 5'd0,  7'h42};
        tvec[3] = '{7'd0,  5'd1,  7'h20};
        tvec[4] = '{7'd0,  5'd2,  7'h7E};
        tvec[5] = '{7'd1,  5'd2,  7'h61};
        tvec[6] = '{7'd3,  5'd2,  7'h61};
        tvec[7] = '{7'd4,  5'd2,  7'h20};
        tvec[8] = '{7'd78, 5'd29, 7'h5A};
        tvec[9] = '{7'd79, 5'd29, 7'h42};

        reset_n         = 1'b0;
        video_on        = 1'b0;
        pixel_x         = '0;
        pixel_y         = '0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_char  = '0;
        wr_bus.clr_req  = 1'b0;
        repeat (3) cycle();

        check("reset busy", 32'(wr_bus.busy), 32'd1);
        check("reset wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        check("reset cursor_x", 32'(wr_bus.cursor_x), 32'd0);
        check("reset cursor_y", 32'(wr_bus.cursor_y), 32'd0);
        check("reset rgb_text", 32'(rgb_text), 32'(BG));
        check("reset rom_addr", 32'(rom_addr), 32'd0);

        reset_n = 1'b1;
        wait_idle(n);
        check("initial clear length", 32'(n), 32'd2400);
        check("wr_ready after clear", 32'(wr_bus.wr_ready), 32'd1);
        read_cell(7'd0, 5'd0, v);
        check("blank cell rom_addr", 32'(rom_addr), 32'h200);

        put_char(7'h41);
        check("A cursor_x", 32'(wr_bus.cursor_x), 32'd1);
        check("A cursor_y", 32'(wr_bus.cursor_y), 32'd0);

        // Latency: pixel (3,5) presented before edge 1, colour appears after edge 3.
        video_on = 1'b0;
        repeat (3) cycle();
        pixel_x  = 10'd3;
        pixel_y  = 10'd5;
        video_on = 1'b1;
        cycle();
        check("pixel (3,5) rom_addr", 32'(rom_addr), 32'h415);
        check("rgb after 1 clk", 32'(rgb_text), 32'(BG));
        video_on = 1'b0;
        cycle();
        check("rgb after 2 clk", 32'(rgb_text), 32'(BG));
        cycle();
        check("rgb after 3 clk", 32'(rgb_text), 32'(FG));
        cycle();
        check("rgb after 4 clk", 32'(rgb_text), 32'(BG));

        probe_pixel(10'd4, 10'd5, 1'b1, rgb);
        check("pixel (4,5) glyph bit clear", 32'(rgb), 32'(BG));
        probe_pixel(10'd8, 10'd0, 1'b1, rgb);
        check("pixel (8,0) solid glyph", 32'(rgb), 32'(FG));
        probe_pixel(10'd640, 10'd5, 1'b1, rgb);
        check("pixel col 80 out of range", 32'(rgb), 32'(BG));

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < cvec[i].reps; r++) put_char(cvec[i].ch);
            check($sformatf("char vec %0d cursor_x", i), 32'(wr_bus.cursor_x), 32'(cvec[i].exp_x));
            check($sformatf("char vec %0d cursor_y", i), 32'(wr_bus.cursor_y), 32'(cvec[i].exp_y));
        end

        for (int i = 0; i < 10; i++) begin
            read_cell(tvec[i].col, tvec[i].row, v);
            check($sformatf("cell (%0d,%0d)", tvec[i].col, tvec[i].row), 32'(v), 32'(tvec[i].exp));
        end

        // clr_req together with a write: clear wins, the char is dropped.
        put_char(7'h44);
        put_char(7'h44);
        check("pre-collision cursor_x", 32'(wr_bus.cursor_x), 32'd2);
        wr_bus.clr_req  = 1'b1;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_char  = 7'h43;
        #1;
        check("collision wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        cycle();
        wr_bus.clr_req  = 1'b0;
        wr_bus.wr_valid = 1'b0;
        check("collision busy", 32'(wr_bus.busy), 32'd1);
        check("collision cursor_x", 32'(wr_bus.cursor_x), 32'd0);
        check("collision cursor_y", 32'(wr_bus.cursor_y), 32'd0);
        read_cell(7'd2, 5'd0, v);
        check("collision char not written", 32'(v), 32'h42);
        wr_bus.clr_req = 1'b1;
        cycle();
        wr_bus.clr_req = 1'b0;
        wait_idle(n);
        check("clr_req ignored during clear", 32'(n + 2), 32'd2400);
        read_cell(7'd2, 5'd0, v);
        check("cell cleared to space", 32'(v), 32'h20);

        // Reset 1000 cells into a clear restarts the full sweep.
        wr_bus.clr_req = 1'b1;
        cycle();
        wr_bus.clr_req = 1'b0;
        repeat (1000) cycle();
        reset_n = 1'b0;
        cycle();
        check("mid-clear reset busy", 32'(wr_bus.busy), 32'd1);
        check("mid-clear reset wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        reset_n = 1'b1;
        wait_idle(n);
        check("restarted clear length", 32'(n), 32'd2400);
        check("wr_ready after restart", 32'(wr_bus.wr_ready), 32'd1);

        probe_pixel(10'd8, 10'd0, 1'b0, rgb);
        check("video_on low gives background", 32'(rgb), 32'(BG));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/text_screen_ctrl.md
Name: text_screen_ctrl

Overview:
- Character-screen controller for the VGA text path: owns an 80x30 tile RAM holding 7-bit ASCII codes.
- Sequences the external font ROM (11-bit address {char, row}, 8-bit word, 1-cycle synchronous read) and produces registered rgb_text.
- Accepts characters from a UART/keyboard writer through a valid/ready port, with cursor tracking, wrap and a hardware clear-screen FSM.
- Sits between the VGA sync generator and the RGB output mux.

Parameters:
- COLS, 80, characters per row (8-pixel-wide glyphs); COLS <= 128.
- ROWS, 30, character rows (16-pixel-tall glyphs); ROWS <= 32.
- FG_RGB, 3'b010, foreground colour.
- BG_RGB, 3'b000, background colour.
- BLINK_FRAMES, 30, frames per cursor blink phase (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- video_on  in  1  visible-area flag from the sync generator
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- wr_valid  in  1  character write request
- wr_char  in  7  ASCII code
- wr_ready  out  1  controller accepts wr_char this cycle
- clr_req  in  1  single-cycle clear-screen request
- busy  out  1  clear in progress
- cursor_x  out  7  cursor column
- cursor_y  out  5  cursor row
- rom_addr  out  11  font ROM address {char[6:0], glyph_row[3:0]}
- font_word  in  8  font ROM data, valid 1 clk after rom_addr
- rgb_text  out  3  pixel colour, registered

Behaviour:
- Tile RAM: 4096x7, address {row[4:0], col[6:0]}. One synchronous read port for display, one write port for the FSM.
- Display pipeline:
  - Edge k: sample col = pixel_x[9:3], row = pixel_y[8:4] into the tile RAM read. Delay glyph_row = pixel_y[3:0], bit = pixel_x[2:0] and video_on alongside.
  - k+1: rom_addr = {tile_data, glyph_row_d1}, combinational from registered data.
  - k+2: font_word valid.
  - Edge k+3: rgb_text = FG_RGB if video_on_d2 and font_word[~bit_d2], else BG_RGB.
  - Fixed latency: 3 clk. Pixels with col >= COLS or row >= ROWS give BG_RGB.
- FSM states: CLEAR, IDLE.
  - CLEAR: each clk writes 0x20 at (clr_col, clr_row). The counter runs col-major inner from (0,0) to (COLS-1, ROWS-1), i.e. COLS*ROWS cycles. Then goes to IDLE.
  - busy = 1 and wr_ready = 0 throughout CLEAR.
  - IDLE: wr_ready = ~clr_req. A character is accepted when wr_valid & wr_ready.
  - IDLE with clr_req: go to CLEAR, cursor to (0,0), clear counter to 0. clr_req wins over a simultaneous wr_valid; the char is not accepted.
  - clr_req during CLEAR is ignored.
- Character handling (one accepted char per clk, written the same edge):
  - 0x20..0x7E: write at cursor, then advance.
    - col = COLS-1 → col 0, row+1.
    - row = ROWS-1 on wrap → row 0. No scrolling.
  - 0x0D: col = 0.
  - 0x0A: col = 0, row+1 with the same wrap.
  - 0x08: if col > 0, col-1 and write 0x20 at the new position; at col 0 no change.
  - Other codes: accepted and dropped.
- Reset (reset_n low at an edge):
  - State CLEAR, clear counter 0, cursor (0,0).
  - Outputs: busy = 1, wr_ready = 0, rgb_text = BG_RGB, cursor_x = 0, cursor_y = 0.
  - All pipeline registers 0, so rom_addr = 0.
  - Reset mid-clear restarts the clear from (0,0).
- The display reads continuously, including during CLEAR. Partially cleared frames are acceptable.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - A frame counter increments on each clk where pixel_x == 0 and pixel_y == 0.
  - At BLINK_FRAMES it wraps to 0 and toggles blink_on (reset 0).
  - When blink_on = 1, in IDLE, the pipeline pixel whose (col, row) equals the cursor has FG_RGB/BG_RGB swapped, video_on permitting.
- Undefined: no counter, no cursor rendering; the cursor is visible only via cursor_x/cursor_y.

Test Plan:
- Release reset → busy = 1 and wr_ready = 0 for exactly 2400 clk, then busy = 0 and wr_ready = 1. Pixel (0,0) then gives rom_addr = {7'h20, 4'h0}.
- After clear, write 0x41 → cursor (1,0). Pixel (3,5) gives rom_addr = 11'h415. With font_word = 8'h10 and bit 3, rgb_text = 3'b010 exactly 3 clk after the pixel is presented.
- Write 80 printable chars → cursor (0,1). Starting from (79,29), write 0x42 → cell (79,29) = 0x42, cursor (0,0).
- Cursor (5,2): send 0x08 → cursor (4,2), cell = 0x20. Send 0x0D → (0,2). Send 0x08 at col 0 → cursor unchanged.
- In IDLE, assert clr_req and wr_valid in the same clk with 0x43 → wr_ready = 0, busy next clk, cell (cursor) not 0x43, cursor (0,0).
- Drive reset_n low at clear count 1000 → busy stays 1, count restarts, 2400 further clk until wr_ready = 1. video_on = 0 → rgb_text = 3'b000 regardless of font_word.
